// File: rtl/joy_pkg.sv
// Shared types and constants for the joystick port latch: the packed joystick word,
// the port offsets at 0x250..0x253 and the default filter parameters.
package joy_pkg;

    typedef struct packed {
        logic [1:0]  jtype;
        logic [11:0] status;
    } joy_state_t;

    localparam int JOY_W = 14;

    localparam logic [1:0] OFS_J1_LO = 2'd0;
    localparam logic [1:0] OFS_J1_HI = 2'd1;
    localparam logic [1:0] OFS_J2_LO = 2'd2;
    localparam logic [1:0] OFS_J2_HI = 2'd3;

    localparam int DEF_STABLE_CNT  = 16;
    localparam int DEF_SYNC_STAGES = 2;

    localparam joy_state_t JOY_RESET = '0;

    function automatic logic [7:0] joy_lo_byte(joy_state_t s);
        return s.status[7:0];
    endfunction

    // The high byte carries the type in the top two bits, then two zero bits,
    // then the upper status nibble.
    function automatic logic [7:0] joy_hi_byte(joy_state_t s);
        return {s.jtype, 2'b00, s.status[11:8]};
    endfunction

endpackage

// File: rtl/joy_filter.sv
// Brings one asynchronous joystick word into clk14 and accepts a new value only
// after it has been seen unchanged for STABLE_CNT consecutive clock samples.
module joy_filter
    import joy_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STABLE_CNT  = DEF_STABLE_CNT
) (
    input  logic       clk14,
    input  logic       reset,
    input  joy_state_t raw_i,
    output joy_state_t stable_o,
    output logic       chg_o
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CNT - 1);

    joy_state_t [SYNC_STAGES-1:0] sync_q;
    joy_state_t                   sync_w;

    joy_state_t cand_q, cand_d;
    joy_state_t stable_q, stable_d;
    logic [7:0] cnt_q, cnt_d;

    always_ff @(posedge clk14 or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw_i};
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

    // Any difference from the candidate restarts the count; once the count
    // reaches its last value it saturates and the candidate is committed.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_w != cand_q) begin
            cand_d = sync_w;
            cnt_d  = 8'd0;
        end else if (cnt_q < CNT_LAST) begin
            cnt_d = cnt_q + 8'd1;
        end else begin
            stable_d = cand_q;
        end
    end

    always_ff @(posedge clk14 or posedge reset) begin
        if (reset) begin
            cand_q   <= JOY_RESET;
            cnt_q    <= 8'd0;
            stable_q <= JOY_RESET;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;
    assign chg_o    = (stable_d != stable_q);

endmodule

// File: rtl/joy_port_latch.sv
// ISA joystick port block at 0x250..0x253: filtered per-joystick state, a snapshot
// taken on each low-byte read so the high byte matches it, and sticky change flags.
module joy_port_latch
    import joy_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int STABLE_CNT  = DEF_STABLE_CNT
) (
    input  logic        clk14,
    input  logic        reset,
    input  logic [11:0] status1,
    input  logic [1:0]  type1,
    input  logic [11:0] status2,
    input  logic [1:0]  type2,
    input  logic        rd_stb,
    input  logic [1:0]  rd_addr,
    output logic [7:0]  rd_data,
    output logic [1:0]  changed
);

    joy_state_t raw1_w, raw2_w;
    joy_state_t stable1_w, stable2_w;
    logic       chg1_w, chg2_w;

    joy_state_t snap1_q, snap1_d;
    joy_state_t snap2_q, snap2_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic [1:0] changed_q, changed_d;

    assign raw1_w = '{jtype: type1, status: status1};
    assign raw2_w = '{jtype: type2, status: status2};

    joy_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE_CNT  (STABLE_CNT)
    ) u_filter1 (
        .clk14    (clk14),
        .reset    (reset),
        .raw_i    (raw1_w),
        .stable_o (stable1_w),
        .chg_o    (chg1_w)
    );

    joy_filter #(
        .SYNC_STAGES (SYNC_STAGES),
        .STABLE_CNT  (STABLE_CNT)
    ) u_filter2 (
        .clk14    (clk14),
        .reset    (reset),
        .raw_i    (raw2_w),
        .stable_o (stable2_w),
        .chg_o    (chg2_w)
    );

    // Reads use the registered stable values, so a commit on the same edge is
    // not yet visible; the flag set is applied after the clear so it wins.
    always_comb begin
        snap1_d   = snap1_q;
        snap2_d   = snap2_q;
        rd_data_d = rd_data_q;
        changed_d = changed_q;
        if (rd_stb) begin
            unique case (rd_addr)
                OFS_J1_LO: begin
                    snap1_d      = stable1_w;
                    rd_data_d    = joy_lo_byte(stable1_w);
                    changed_d[0] = 1'b0;
                end
                OFS_J1_HI: rd_data_d = joy_hi_byte(snap1_q);
                OFS_J2_LO: begin
                    snap2_d      = stable2_w;
                    rd_data_d    = joy_lo_byte(stable2_w);
                    changed_d[1] = 1'b0;
                end
                OFS_J2_HI: rd_data_d = joy_hi_byte(snap2_q);
                default:   rd_data_d = rd_data_q;
            endcase
        end
        if (chg1_w) changed_d[0] = 1'b1;
        if (chg2_w) changed_d[1] = 1'b1;
    end

    always_ff @(posedge clk14 or posedge reset) begin
        if (reset) begin
            snap1_q   <= JOY_RESET;
            snap2_q   <= JOY_RESET;
            rd_data_q <= 8'h00;
            changed_q <= 2'b00;
        end else begin
            snap1_q   <= snap1_d;
            snap2_q   <= snap2_d;
            rd_data_q <= rd_data_d;
            changed_q <= changed_d;
        end
    end

    assign rd_data = rd_data_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_joy_port_latch.sv
// Self-checking bench for joy_port_latch with STABLE_CNT=4, SYNC_STAGES=2; read
// results are queued when the strobe is driven and compared when rd_data updates.
`timescale 1ns/1ps
module tb_joy_port_latch;

    logic        clk14 = 1'b0;
    logic        reset;
    logic [11:0] status1, status2;
    logic [1:0]  type1, type2;
    logic        rd_stb;
    logic [1:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [1:0]  changed;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_exp;

    always #35 clk14 = ~clk14;

    joy_port_latch #(
        .SYNC_STAGES (2),
        .STABLE_CNT  (4)
    ) dut (
        .clk14   (clk14),
        .reset   (reset),
        .status1 (status1),
        .type1   (type1),
        .status2 (status2),
        .type2   (type2),
        .rd_stb  (rd_stb),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .changed (changed)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk14);
    endtask

    task automatic rd(input logic [1:0] addr, input logic [7:0] exp);
        rd_stb  = 1'b1;
        rd_addr = addr;
        exp_q.push_back(exp);
        @(negedge clk14);
        rd_stb = 1'b0;
        if (exp_q.size() == 0) begin
            chk("rd_queue", 16'h1, 16'h0);
        end else begin
            last_exp = exp_q.pop_front();
            chk($sformatf("rd_ofs%0d", addr), {8'h00, rd_data}, {8'h00, last_exp});
        end
    endtask

    initial begin
        reset   = 1'b1;
        status1 = 12'h000;
        status2 = 12'h000;
        type1   = 2'b00;
        type2   = 2'b00;
        rd_stb  = 1'b0;
        rd_addr = 2'd0;
        tick(3);
        chk("rst_rd_data", {8'h00, rd_data}, 16'h0000);
        chk("rst_changed", {14'h0, changed}, 16'h0000);
        reset = 1'b0;
        tick(20);
        chk("idle_changed", {14'h0, changed}, 16'h0000);

        // Clean step: commit lands exactly on the 7th edge.
        status1 = 12'hA5C;
        tick(6);
        chk("step_lat6", {14'h0, changed}, 16'h0000);
        tick(1);
        chk("step_lat7", {14'h0, changed}, 16'h0001);
        rd(2'd0, 8'h5C);
        chk("step_clr", {14'h0, changed}, 16'h0000);
        rd(2'd1, 8'h0A);

        // Fast toggling never commits.
        status1 = 12'h000;
        tick(10);
        rd(2'd0, 8'h00);
        chk("base_clr", {14'h0, changed}, 16'h0000);
        for (int i = 0; i < 50; i++) begin
            status1 = ((i / 3) % 2 == 0) ? 12'h001 : 12'h000;
            tick(1);
            chk("toggle_changed", {14'h0, changed}, 16'h0000);
        end
        status1 = 12'h000;
        rd(2'd0, 8'h00);
        rd(2'd1, 8'h00);

        // High byte comes from the snapshot, not the live stable value.
        type1   = 2'b10;
        status1 = 12'h3C1;
        tick(10);
        rd(2'd0, 8'hC1);
        status1 = 12'hFFF;
        tick(10);
        chk("settle_changed", {14'h0, changed}, 16'h0001);
        rd(2'd1, 8'h83);
        rd(2'd0, 8'hFF);
        rd(2'd1, 8'h8F);
        tick(5);
        chk("hold_rd_data", {8'h00, rd_data}, 16'h008F);

        // Commit and low-byte read on the same edge.
        status1 = 12'h123;
        tick(6);
        rd(2'd0, 8'hFF);
        chk("coll_changed", {14'h0, changed}, 16'h0001);
        rd(2'd0, 8'h23);
        chk("coll_clr", {14'h0, changed}, 16'h0000);

        // Reset mid-filter, then recommit after release.
        type1   = 2'b00;
        status1 = 12'h055;
        tick(5);
        #10 reset = 1'b1;
        #1;
        chk("midrst_rd_data", {8'h00, rd_data}, 16'h0000);
        chk("midrst_changed", {14'h0, changed}, 16'h0000);
        exp_q.delete();
        tick(3);
        reset = 1'b0;
        tick(6);
        chk("rerun_lat6", {14'h0, changed}, 16'h0000);
        tick(1);
        chk("rerun_lat7", {14'h0, changed}, 16'h0001);
        rd(2'd0, 8'h55);
        rd(2'd1, 8'h00);

        // Both joysticks at once, then joystick 2 alone.
        status1 = 12'h9AB;
        type1   = 2'b01;
        status2 = 12'h7E4;
        type2   = 2'b11;
        tick(10);
        chk("dual_changed", {14'h0, changed}, 16'h0003);
        rd(2'd0, 8'hAB);
        chk("dual_clr1", {14'h0, changed}, 16'h0002);
        rd(2'd2, 8'hE4);
        chk("dual_clr2", {14'h0, changed}, 16'h0000);
        rd(2'd1, 8'h49);
        rd(2'd3, 8'hC7);
        status2 = 12'h001;
        tick(10);
        chk("j2_only_changed", {14'h0, changed}, 16'h0002);
        rd(2'd1, 8'h49);
        rd(2'd2, 8'h01);
        rd(2'd3, 8'hC0);
        chk("j2_only_clr", {14'h0, changed}, 16'h0000);

        if (exp_q.size() != 0) chk("queue_empty", 16'(exp_q.size()), 16'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/joy_port_latch.md
JOY_PORT_LATCH -- requirements
Module: joy_port_latch

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth (2..3).
REQ-002 SHALL have parameter STABLE_CNT, default 16, consecutive equal clk14 samples required to accept a new value (1..255).
REQ-003 SHALL have port clk14  input  1  ISA 14 MHz clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port status1  input  12  joystick 1 button status from the scanner, asynchronous to clk14.
REQ-006 SHALL have port type1  input  2  joystick 1 type from the scanner, asynchronous to clk14.
REQ-007 SHALL have port status2  input  12  joystick 2 button status, asynchronous.
REQ-008 SHALL have port type2  input  2  joystick 2 type, asynchronous.
REQ-009 SHALL have port rd_stb  input  1  one-cycle port-read strobe from the ISA decoder, clk14 domain.
REQ-010 SHALL have port rd_addr  input  2  port offset 0..3 (0x250..0x253), valid with rd_stb.
REQ-011 SHALL have port rd_data  output  8  registered read byte.
REQ-012 SHALL have port changed  output  2  sticky per-joystick change flags, bit0 = joystick 1.

Function
REQ-013 SHALL pass each 14-bit {type,status} word through a SYNC_STAGES flop chain into clk14.
REQ-014 Filter SHALL hold candidate, 8-bit counter cnt, stable; when sync != candidate: candidate <= sync, cnt <= 0.
REQ-015 When sync == candidate and cnt < STABLE_CNT-1: cnt increments; when cnt == STABLE_CNT-1: stable <= candidate, cnt holds (saturates).
REQ-016 A clean input step SHALL appear in stable on the (SYNC_STAGES+STABLE_CNT+1)th clk14 edge after the step, +1 edge metastability tolerance.
REQ-017 An input toggling faster than STABLE_CNT cycles SHALL never reach stable; each change restarts cnt at 0.
REQ-018 On rd_stb with rd_addr=0: snap1 <= stable1 and rd_data <= stable1.status[7:0] on the same edge (bypass).
REQ-019 On rd_stb with rd_addr=1: rd_data <= {snap1.type, 2'b00, snap1.status[11:8]}; snap1 unchanged.
REQ-020 Offsets 2 and 3 SHALL behave as REQ-018/019 for joystick 2 (snap2, stable2).
REQ-021 High-byte reads SHALL always return the snapshot of the last low-byte read, even if stable has since changed.
REQ-022 rd_data SHALL hold its value when rd_stb = 0.
REQ-023 changed[n] SHALL set on the edge stable_n is loaded with a value differing from its previous value.
REQ-024 changed[n] SHALL clear on a low-byte read (offset 0 or 2) of joystick n.
REQ-025 Commit and low-byte read on the same edge: snapshot takes the pre-commit stable value and changed stays set (set wins).
REQ-026 Joysticks SHALL be fully independent; simultaneous activity on both has no interaction.

Reset
REQ-027 Reset SHALL clear sync chains, candidate, stable, snap1, snap2 to 14'h0000, cnt to 0, rd_data to 8'h00, changed to 2'b00.
REQ-028 Reset asserted mid-filter or mid-read SHALL abort immediately; after release a stable input re-commits after the REQ-016 latency.
REQ-029 A commit from all-zero reset state to a nonzero input SHALL set changed.

Structure
REQ-030 Package joy_pkg SHALL hold joy_state_t (packed {type[1:0], status[11:0]}), port offset constants, and STABLE_CNT/SYNC_STAGES defaults.
REQ-031 Sync plus filter SHALL be sub-module joy_filter, instantiated once per joystick; snapshot, read mux and flags stay in joy_port_latch.

Verification (STABLE_CNT=4, SYNC_STAGES=2)
REQ-032 status1 0x000->0xA5C at a clean edge -> stable1 = 0xA5C exactly 7 edges later, changed = 2'b01.
REQ-033 status1 toggling 0x001/0x000 every 3 cycles for 50 cycles -> stable1 and changed never move.
REQ-034 Stable 0x3C1 type 2'b10, read offset 0 -> rd_data 0xC1; input -> 0xFFF settles; read offset 1 -> rd_data 0x83.
REQ-035 Commit and offset-0 read on the same edge -> rd_data is the old low byte, changed[0] remains 1; next offset-0 read returns new byte and clears it.
REQ-036 Reset pulsed at cnt=2 -> all outputs 0; after release input 0x055 commits 7 edges later.
REQ-037 Both joysticks stepped simultaneously, reads at offsets 0,2,1,3 -> each byte matches its own joystick, changed cleared per joystick.
